imem_boot_loader: RTL and testbench

Boot-time sequencer for the instruction memory of the RISC SoC. It holds the pipelined core in reset and receives a program image as a byte stream over a valid/ready handshake. It writes the image word-by-word into IMEM through IMEM's write port, verifies an XOR checksum, and releases the core only after a verified load. It sits between the external loader interface and the IMEM write port, and drives the core's reset.

---
 rtl/imem_boot_loader_if.sv | 20 ++
 rtl/imem_boot_loader.sv | 106 ++++++++++
 tb/tb_imem_boot_loader.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// Loader-side stream handshake plus IMEM write port of the boot loader.
// The boot loader takes the slave modport; the image source and the IMEM side use master.
interface imem_boot_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] imem_addr;
    logic [15:0] imem_wdata;
    logic        imem_wr;

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_addr, imem_wdata, imem_wr
    );

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_addr, imem_wdata, imem_wr
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot sequencer: receives a length-prefixed, XOR-checksummed byte image and writes it into IMEM.
// Holds the core in reset until a load has been verified.
module imem_boot_loader #(
    parameter int unsigned imem_size = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    imem_boot_loader_if.slave    ldr,
    output logic                 core_rst_n,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    typedef enum logic [3:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    localparam logic [16:0] SIZE_LIM = 17'(imem_size);

    state_t      state, state_n;
    logic [15:0] len;
    logic [15:0] idx;
    logic [15:0] wdata;
    logic [7:0]  csum;
    logic        rx_ready_q;
    logic        imem_wr_q;
    logic        accept;
    logic        start_ok;
    logic [15:0] len_rx;

    assign accept   = ldr.rx_valid && rx_ready_q;
    assign start_ok = start && (state inside {S_IDLE, S_DONE, S_ERR});
    assign len_rx   = {len[15:8], ldr.rx_data};

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:    if (start_ok) state_n = S_LEN_HI;
            S_LEN_HI:  if (accept) state_n = S_LEN_LO;
            S_LEN_LO: begin
                if (accept) begin
                    if ({1'b0, len_rx} > SIZE_LIM) state_n = S_ERR;
                    else if (len_rx == '0)         state_n = S_CSUM;
                    else                           state_n = S_DATA_HI;
                end
            end
            S_DATA_HI: if (accept) state_n = S_DATA_LO;
            S_DATA_LO: if (accept) state_n = S_WRITE;
            S_WRITE:   state_n = ((idx + 16'd1) == len) ? S_CSUM : S_DATA_HI;
            S_CSUM: begin
                if (accept) state_n = (ldr.rx_data == csum) ? S_DONE : S_ERR;
            end
            S_DONE, S_ERR: if (start_ok) state_n = S_LEN_HI;
            default:   state_n = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rx_ready_q <= 1'b0;
            imem_wr_q  <= 1'b0;
            core_rst_n <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            len        <= '0;
            idx        <= '0;
            wdata      <= '0;
            csum       <= '0;
        end else begin
            state      <= state_n;
            rx_ready_q <= state_n inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM};
            imem_wr_q  <= (state_n == S_WRITE);
            core_rst_n <= (state_n == S_DONE);
            busy       <= !(state_n inside {S_IDLE, S_DONE, S_ERR});
            done       <= (state_n == S_DONE);
            err        <= (state_n == S_ERR);

            if (start_ok) begin
                csum <= '0;
                idx  <= '0;
            end else begin
                if (accept) csum <= csum ^ ldr.rx_data;
                if (state == S_WRITE) idx <= idx + 16'd1;
            end

            if (accept) begin
                unique case (state)
                    S_LEN_HI:  len[15:8]   <= ldr.rx_data;
                    S_LEN_LO:  len[7:0]    <= ldr.rx_data;
                    S_DATA_HI: wdata[15:8] <= ldr.rx_data;
                    S_DATA_LO: wdata[7:0]  <= ldr.rx_data;
                    default: ;
                endcase
            end
        end
    end

    assign ldr.rx_ready   = rx_ready_q;
    assign ldr.imem_wr    = imem_wr_q;
    assign ldr.imem_addr  = idx;
    assign ldr.imem_wdata = wdata;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: stimulus queues expected IMEM writes and load results,
// a negedge monitor pops and compares them as the DUT presents writes and end-of-load.
module tb_imem_boot_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic core_rst_n, busy, done, err;

    imem_boot_loader_if bus ();

    imem_boot_loader #(.imem_size(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ldr        (bus.slave),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_result;
        logic [15:0] addr;
        logic [15:0] data;
        bit          done;
        bit          err;
    } exp_t;

    exp_t sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    bit prev_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_write(input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        e.is_result = 1'b0; e.addr = a; e.data = d; e.done = 1'b0; e.err = 1'b0;
        sb.push_back(e);
    endfunction

    function automatic void push_result(input bit d, input bit e_);
        exp_t e;
        e.is_result = 1'b1; e.addr = '0; e.data = '0; e.done = d; e.err = e_;
        sb.push_back(e);
    endfunction

    // Monitor: consumes one expectation per write pulse and per end of a load.
    always @(negedge clk) begin
        exp_t e;
        if (bus.imem_wr) begin
            check("rx_ready_during_write", bus.rx_ready, 0);
            check("write_expected", (sb.size() != 0 && !sb[0].is_result), 1);
            if (sb.size() != 0 && !sb[0].is_result) begin
                e = sb.pop_front();
                check("imem_addr", bus.imem_addr, e.addr);
                check("imem_wdata", bus.imem_wdata, e.data);
            end
        end
        if (prev_busy && !busy) begin
            check("result_expected", (sb.size() != 0 && sb[0].is_result), 1);
            if (sb.size() != 0 && sb[0].is_result) begin
                e = sb.pop_front();
                check("done", done, e.done);
                check("err", err, e.err);
                check("core_rst_n", core_rst_n, e.done);
            end
        end
        prev_busy = busy;
    end

    task automatic send_byte(input logic [7:0] b, input int unsigned gap, input bit stray);
        int unsigned waited = 0;
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        start        = stray;
        while (!bus.rx_ready && waited < 200) begin
            @(negedge clk);
            start = 1'b0;
            waited++;
        end
        if (!bus.rx_ready) check("byte_accept_timeout", bus.rx_ready, 1);
        @(negedge clk);
        start        = 1'b0;
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] s[$], input bit gaps);
        int unsigned gap_tab[7] = '{2, 0, 3, 1, 0, 4, 2};
        for (int unsigned i = 0; i < s.size(); i++) begin
            if (gaps) send_byte(s[i], gap_tab[i % 7], (i % 2) == 1);
            else      send_byte(s[i], 0, 1'b0);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"}, bus.rx_ready, 0);
        check({tag, "_imem_wr"}, bus.imem_wr, 0);
        check({tag, "_imem_addr"}, bus.imem_addr, 0);
        check({tag, "_imem_wdata"}, bus.imem_wdata, 0);
        check({tag, "_core_rst_n"}, core_rst_n, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        logic [7:0] s[$];
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic load: 00^02^12^34^AB^CD = 0x42
        pulse_start();
        check("start_rx_ready", bus.rx_ready, 1);
        check("start_busy", busy, 1);
        push_write(16'h0000, 16'h1234);
        push_write(16'h0001, 16'hABCD);
        push_result(1, 0);
        s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_stream(s, 0);

        // Bad checksum from DONE: words still land, load ends in ERR
        pulse_start();
        check("restart_core_rst_n", core_rst_n, 0);
        push_write(16'h0000, 16'h1234);
        push_write(16'h0001, 16'hABCD);
        push_result(0, 1);
        s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        send_stream(s, 0);

        // Length overflow: 65 > 64
        pulse_start();
        push_result(0, 1);
        s = '{8'h00, 8'h41};
        send_stream(s, 0);
        check("overflow_rx_ready", bus.rx_ready, 0);

        // Zero length
        pulse_start();
        push_result(1, 0);
        s = '{8'h00, 8'h00, 8'h00};
        send_stream(s, 0);

        // Full length: word i = {i,i}, pairs cancel so checksum = 00^40
        pulse_start();
        s = '{8'h00, 8'h40};
        for (int unsigned i = 0; i < 64; i++) begin
            s.push_back(8'(i));
            s.push_back(8'(i));
            push_write(16'(i), {8'(i), 8'(i)});
        end
        s.push_back(8'h40);
        push_result(1, 0);
        send_stream(s, 0);

        // Gaps and stray start pulses while busy
        pulse_start();
        push_write(16'h0000, 16'h1234);
        push_write(16'h0001, 16'hABCD);
        push_result(1, 0);
        s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_stream(s, 1);

        // Asynchronous reset after the first DATA_HI
        pulse_start();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h12, 0, 1'b0);
        push_result(0, 0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fresh load, then restart from DONE loads a new image from address 0
        pulse_start();
        push_write(16'h0000, 16'h1234);
        push_write(16'h0001, 16'hABCD);
        push_result(1, 0);
        s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_stream(s, 0);
        pulse_start();
        check("reload_core_rst_n", core_rst_n, 0);
        check("reload_addr", bus.imem_addr, 0);
        // 00^01^BE^EF = 0x50
        push_write(16'h0000, 16'hBEEF);
        push_result(1, 0);
        s = '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h50};
        send_stream(s, 0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
